ivl_uvm_ovl_impli_driver: RTL and testbench

- Synthesizable stimulus generator and scoreboard for the `ovl_implication` checker in the ivl_uvm OVL test suite.
- Drives `antecedent_expr`/`consequent_expr` pairs: legal pairs, injected violating pairs, and vacuous consequent-only toggles.
- Counts the checker's fire pulses and compares them with the number of violations it injected.
- Reports pass/fail once per run, so OVL pass/fail tests self-check instead of relying on waveform inspection.

---
 rtl/ivl_uvm_ovl_impli_driver.sv | 176 +++++++++++++++++
 tb/tb_ivl_uvm_ovl_impli_driver.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ivl_uvm_ovl_impli_driver.sv
// Stimulus generator and fire scoreboard for the ovl_implication checker.
// Drives antecedent/consequent pairs, injects violations, compares fires.
module ivl_uvm_ovl_impli_driver #(
  parameter int GAP_CYCLES   = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pairs,
  input  logic [CNT_W-1:0] viol_period,
  input  logic             fire_in,
  output logic             antecedent_expr,
  output logic             consequent_expr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] exp_fire_cnt,
  output logic [CNT_W-1:0] obs_fire_cnt,
  output logic             stray_fire
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] DRN_LD = 4'(DRAIN_CYCLES - 1);

  state_t           r_st;
  logic [CNT_W-1:0] r_npairs;
  logic [CNT_W-1:0] r_vper;
  logic [CNT_W-1:0] r_vcnt;
  logic [CNT_W-1:0] r_pcnt;
  logic [3:0]       r_tmr;
  logic             r_ant;
  logic             r_con;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_exp;
  logic [CNT_W-1:0] r_obs;
  logic             r_stray;

  logic             w_idle;
  logic [CNT_W-1:0] w_vp;
  logic [CNT_W-1:0] w_vc;
  logic             w_viol;
  logic [CNT_W-1:0] w_vc_nxt;
  logic [CNT_W-1:0] w_exp_nxt;
  logic [CNT_W-1:0] w_pcnt_nxt;
  logic             w_count;
  logic [CNT_W-1:0] w_obs_nxt;

  // Entering ASSERT from IDLE uses the freshly presented period,
  // since the latch and the first pair happen on the same edge.
  assign w_idle   = (r_st == S_IDLE);
  assign w_vp     = w_idle ? viol_period : r_vper;
  assign w_vc     = w_idle ? viol_period : r_vcnt;
  assign w_viol   = (w_vp != '0) && (w_vc == CNT_W'(1));
  assign w_vc_nxt = w_viol          ? w_vp :
                    (w_vp != '0)    ? w_vc - CNT_W'(1) :
                                      w_vc;
  assign w_exp_nxt  = (w_idle ? '0 : r_exp) + CNT_W'(w_viol);
  assign w_pcnt_nxt = (w_idle ? '0 : r_pcnt) + CNT_W'(1);

  assign w_count = fire_in &&
                   (r_st == S_ASSERT || r_st == S_GAP ||
                    r_st == S_DRAIN);
  assign w_obs_nxt = (w_count && r_obs != '1) ?
                     r_obs + CNT_W'(1) : r_obs;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st     <= S_IDLE;
      r_npairs <= '0;
      r_vper   <= '0;
      r_vcnt   <= '0;
      r_pcnt   <= '0;
      r_tmr    <= '0;
      r_ant    <= 1'b0;
      r_con    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_exp    <= '0;
      r_obs    <= '0;
      r_stray  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_obs  <= w_obs_nxt;
      unique case (r_st)
        S_IDLE: begin
          if (fire_in)
            r_stray <= 1'b1;
          if (start) begin
            r_npairs <= num_pairs;
            r_vper   <= viol_period;
            r_obs    <= '0;
            r_stray  <= 1'b0;
            r_pass   <= 1'b0;
            r_busy   <= 1'b1;
            if (num_pairs != '0) begin
              r_st   <= S_ASSERT;
              r_ant  <= 1'b1;
              r_con  <= !w_viol;
              r_vcnt <= w_vc_nxt;
              r_exp  <= w_exp_nxt;
              r_pcnt <= w_pcnt_nxt;
            end else begin
              r_st   <= S_DRAIN;
              r_tmr  <= DRN_LD;
              r_vcnt <= viol_period;
              r_exp  <= '0;
              r_pcnt <= '0;
            end
          end
        end
        S_ASSERT: begin
          r_st  <= S_GAP;
          r_tmr <= GAP_LD;
          r_ant <= 1'b0;
          r_con <= 1'b1;
        end
        S_GAP: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - 4'd1;
            r_con <= !r_con;
          end else if (r_pcnt < r_npairs) begin
            r_st   <= S_ASSERT;
            r_ant  <= 1'b1;
            r_con  <= !w_viol;
            r_vcnt <= w_vc_nxt;
            r_exp  <= w_exp_nxt;
            r_pcnt <= w_pcnt_nxt;
          end else begin
            r_st  <= S_DRAIN;
            r_tmr <= DRN_LD;
            r_con <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (r_tmr != '0) begin
            r_tmr <= r_tmr - 4'd1;
          end else begin
            r_st   <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_obs_nxt == r_exp) && !r_stray;
          end
        end
        S_DONE: begin
          r_st <= S_IDLE;
        end
        default: begin
          r_st <= S_IDLE;
        end
      endcase
    end
  end

  assign antecedent_expr = r_ant;
  assign consequent_expr = r_con;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign exp_fire_cnt    = r_exp;
  assign obs_fire_cnt    = r_obs;
  assign stray_fire      = r_stray;

endmodule

// File: tb/tb_ivl_uvm_ovl_impli_driver.sv
// Directed plus randomized runs against a per-cycle waveform model.
// Expected pair shape and counts come from the run parameters alone.
module tb_ivl_uvm_ovl_impli_driver;

  localparam int G = 2;
  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] num_pairs;
  logic [W-1:0] viol_period;
  logic         fire_in;
  logic         ant;
  logic         con;
  logic         busy;
  logic         done;
  logic         pass;
  logic [W-1:0] exp_cnt;
  logic [W-1:0] obs_cnt;
  logic         stray;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ivl_uvm_ovl_impli_driver #(
    .GAP_CYCLES  (G),
    .DRAIN_CYCLES(D),
    .CNT_W       (W)
  ) dut (
    .clock          (clk),
    .reset          (reset),
    .start          (start),
    .num_pairs      (num_pairs),
    .viol_period    (viol_period),
    .fire_in        (fire_in),
    .antecedent_expr(ant),
    .consequent_expr(con),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .exp_fire_cnt   (exp_cnt),
    .obs_fire_cnt   (obs_cnt),
    .stray_fire     (stray)
  );

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic bit pair_viol(input int p, input int vp);
    return (vp != 0) && (((p + 1) % vp) == 0);
  endfunction

  // mode: 0 no fires, 1 fire after each violating pair,
  // 2 random fires, 3 fire held high throughout the run
  task automatic run(input int n, input int vp, input int mode,
                     input int restart_at = -1,
                     input bit fire0 = 1'b0);
    int L;
    int fires;
    int p;
    int o;
    int e_exp;
    int e_obs;
    bit ea;
    bit ec;
    L     = 1 + n * (1 + G) + D;
    fires = 0;
    e_exp = 0;
    for (int i = 0; i < n; i++)
      if (pair_viol(i, vp)) e_exp++;
    @(negedge clk);
    num_pairs   = W'(n);
    viol_period = W'(vp);
    start       = 1'b1;
    fire_in     = fire0;
    @(posedge clk);
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) num_pairs = 8'd1;
      p  = (k - 1) / (1 + G);
      o  = (k - 1) % (1 + G);
      ea = 1'b0;
      ec = 1'b0;
      if (p < n) begin
        ea = (o == 0);
        ec = (o == 0) ? !pair_viol(p, vp) : (o % 2 == 1);
      end
      chk($sformatf("wave_k%0d", k), {ant, con, busy, done},
          {ea, ec, (k < L), (k == L)});
      if (k == 1) chk("stray_clr", stray, 1'b0);
      case (mode)
        1: fire_in = (p < n) && (o == 1) && pair_viol(p, vp);
        2: fire_in = ($urandom_range(0, 3) == 0);
        3: fire_in = 1'b1;
        default: fire_in = 1'b0;
      endcase
      if (k == L) begin
        fire_in = 1'b0;
        e_obs = (fires > 255) ? 255 : fires;
        chk("exp_cnt", exp_cnt, e_exp);
        chk("obs_cnt", obs_cnt, e_obs);
        chk("pass", pass, (e_obs == e_exp));
      end
      if (fire_in) fires++;
    end
    @(negedge clk);
    start   = 1'b0;
    fire_in = 1'b0;
    chk("post_idle", {busy, done, ant, con}, 4'b0000);
  endtask

  initial begin
    bit seen_done;
    reset       = 1'b1;
    start       = 1'b0;
    num_pairs   = '0;
    viol_period = '0;
    fire_in     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {ant, con, busy, done, pass, exp_cnt, obs_cnt, stray}, '0);
    reset = 1'b0;

    run(4, 0, 0);
    run(6, 2, 1);
    run(6, 2, 0);
    run(1, 1, 0);
    run(3, 5, 1);

    // stray fire in IDLE, cleared by the next accepted start
    @(negedge clk);
    fire_in = 1'b1;
    @(negedge clk);
    fire_in = 1'b0;
    chk("stray_set", stray, 1'b1);
    run(2, 0, 0, -1, 1'b1);
    @(negedge clk);
    fire_in = 1'b1;
    @(negedge clk);
    fire_in = 1'b0;
    chk("stray_idle", {stray, pass}, 2'b11);

    // reset mid-run
    @(negedge clk);
    num_pairs = 8'd10;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrun_reset",
        {ant, con, busy, done, pass, exp_cnt, obs_cnt, stray}, '0);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    chk("no_done_after_rst", seen_done, 1'b0);

    // start ignored while busy
    run(10, 3, 1, 5);
    run(0, 0, 0);
    run(100, 0, 3);

    for (int r = 0; r < 8; r++)
      run($urandom_range(0, 12), $urandom_range(0, 5), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
